// File: rtl/ysyx_24070016_exu_pkg.sv
// Shared definitions for the EXU issue/sequencing controller: default widths,
// timeout length and the controller state encoding.
package ysyx_24070016_exu_pkg;

  localparam int XLEN    = 32;
  localparam int RD_W    = 5;
  localparam int TMO_CYC = 64;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EXEC  = 3'd1,
    S_MULTI = 3'd2,
    S_WB    = 3'd3,
    S_HALT  = 3'd4
  } state_e;

endpackage

// File: rtl/ysyx_24070016_exu_tmo_cnt.sv
// Watchdog counter for the iterative unit: cleared when a multi op is accepted,
// counts every MULTI cycle and flags expiry once it holds TMO_CYC.
module ysyx_24070016_exu_tmo_cnt #(
  parameter int TMO_CYC = 64,
  parameter int CW      = $clog2(TMO_CYC + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [CW-1:0] o_cnt,
  output logic          o_expired
);

  logic [CW-1:0] r_cnt;
  logic          w_expired;

  assign w_expired = (r_cnt == CW'(TMO_CYC));

  // Saturates at TMO_CYC so a stuck enable can never wrap back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_cnt <= '0;
    else if (i_clr)               r_cnt <= '0;
    else if (i_en && !w_expired)  r_cnt <= r_cnt + CW'(1);
  end

  assign o_cnt     = r_cnt;
  assign o_expired = w_expired;

endmodule

// File: rtl/ysyx_24070016_exu_seq.sv
// EXU issue/sequencing controller: accepts one decoded op, drives ALU operands,
// runs single-cycle or iterative execution, holds the result for WBU, halts on ebreak/timeout.
module ysyx_24070016_exu_seq #(
  parameter int XLEN    = ysyx_24070016_exu_pkg::XLEN,
  parameter int RD_W    = ysyx_24070016_exu_pkg::RD_W,
  parameter int TMO_CYC = ysyx_24070016_exu_pkg::TMO_CYC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_sel_imm,
  input  logic            in_multi,
  input  logic            in_ebreak,
  input  logic [RD_W-1:0] in_rd,
  input  logic            in_wen,
  output logic [XLEN-1:0] alu_src1,
  output logic [XLEN-1:0] alu_src2,
  input  logic [XLEN-1:0] alu_result,
  output logic            mc_start,
  input  logic            mc_done,
  input  logic [XLEN-1:0] mc_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [RD_W-1:0] out_rd,
  output logic            out_wen,
  output logic            halt,
  output logic            halt_err
);
  import ysyx_24070016_exu_pkg::*;

  localparam int CW = $clog2(TMO_CYC + 1);

  state_e          r_state, w_state_nxt;
  logic [XLEN-1:0] r_src1, r_src2, r_result;
  logic [RD_W-1:0] r_rd;
  logic            r_wen, r_halt_err;
  logic            w_acc, w_tmo_err, w_expired;
  logic [CW-1:0]   w_cnt;

  assign w_acc     = in_valid && (r_state == S_IDLE);
  assign w_tmo_err = (r_state == S_MULTI) && !mc_done && w_expired;

  ysyx_24070016_exu_tmo_cnt #(.TMO_CYC(TMO_CYC), .CW(CW)) u_tmo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_acc),
    .i_en      (r_state == S_MULTI),
    .o_cnt     (w_cnt),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // mc_done wins over expiry when both land in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_acc) w_state_nxt = in_ebreak ? S_HALT : (in_multi ? S_MULTI : S_EXEC);
      S_EXEC:  w_state_nxt = S_WB;
      S_MULTI: if (mc_done) w_state_nxt = S_WB;
               else if (w_expired) w_state_nxt = S_HALT;
      S_WB:    if (out_ready) w_state_nxt = S_IDLE;
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ebreak never writes back, so its wen is dropped at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src1 <= '0;
      r_src2 <= '0;
      r_rd   <= '0;
      r_wen  <= 1'b0;
    end else if (w_acc) begin
      r_src1 <= in_src1;
      r_src2 <= in_sel_imm ? in_imm : in_src2;
      r_rd   <= in_rd;
      r_wen  <= in_wen && !in_ebreak;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             r_result <= '0;
    else if (r_state == S_EXEC)             r_result <= alu_result;
    else if (r_state == S_MULTI && mc_done) r_result <= mc_result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_halt_err <= 1'b0;
    else if (w_tmo_err) r_halt_err <= 1'b1;
  end

  assign in_ready   = (r_state == S_IDLE);
  assign alu_src1   = r_src1;
  assign alu_src2   = r_src2;
  assign mc_start   = (r_state == S_MULTI) && (w_cnt == '0);
  assign out_valid  = (r_state == S_WB);
  assign out_result = r_result;
  assign out_rd     = r_rd;
  assign out_wen    = r_wen;
  assign halt       = (r_state == S_HALT);
  assign halt_err   = r_halt_err;

endmodule
